and8_bits_structure: RTL and testbench

- Bitwise 8-bit AND built structurally: one 2-input AND gate per bit pair (A_i, B_i) drives S_i.
- Unregistered S outputs are valid in the same delta; there is no clock latency.
- A registered copy of the result and two registered status flags give downstream synchronous logic a stable, reset-defined view.
- Used as a leaf logic unit in the ALU/logic datapath.

---
 rtl/and8_bits_structure.sv | 91 +++++++++
 tb/tb_and8_bits_structure.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/and8_bits_structure.sv
// -----------------------------------------------------------------------------
// and8_bits_structure
//   Bitwise 8-bit AND leaf unit for the ALU/logic datapath.
//   Each bit pair (A_i, B_i) drives S_i through its own 2-input AND gate
//   primitive. The combinational result is available with zero clock latency.
//   A registered copy of the result and two registered status flags give
//   downstream synchronous logic a stable, reset-defined view.
//
// Ports
//   A1..A8    in   operand A, bit 1 = LSB, bit 8 = MSB
//   B1..B8    in   operand B, bit 1 = LSB, bit 8 = MSB
//   S1..S8    out  combinational result, S_i = A_i & B_i (independent of clk/rst_n)
//   clk       in   rising-edge clock for the registered stage
//   rst_n     in   asynchronous active-low reset
//   q         out  registered result, q[i-1] = S_i sampled at the clk rise
//   all_zero  out  registered flag, 1 when the sampled result is 8'h00
//   all_one   out  registered flag, 1 when the sampled result is 8'hFF
// -----------------------------------------------------------------------------
module and8_bits_structure (
    input  logic       A1,
    input  logic       B1,
    input  logic       A2,
    input  logic       B2,
    input  logic       A3,
    input  logic       B3,
    input  logic       A4,
    input  logic       B4,
    input  logic       A5,
    input  logic       B5,
    input  logic       A6,
    input  logic       B6,
    input  logic       A7,
    input  logic       B7,
    input  logic       A8,
    input  logic       B8,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       S4,
    output logic       S5,
    output logic       S6,
    output logic       S7,
    output logic       S8,
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] q,
    output logic       all_zero,
    output logic       all_one
);

    // One gate per bit pair; no clocked element on this path.
    and g_and1 (S1, A1, B1);
    and g_and2 (S2, A2, B2);
    and g_and3 (S3, A3, B3);
    and g_and4 (S4, A4, B4);
    and g_and5 (S5, A5, B5);
    and g_and6 (S6, A6, B6);
    and g_and7 (S7, A7, B7);
    and g_and8 (S8, A8, B8);

    logic [7:0] s_vec;
    logic [7:0] res_d,      res_q;
    logic       all_zero_d, all_zero_q;
    logic       all_one_d,  all_one_q;

    assign s_vec = {S8, S7, S6, S5, S4, S3, S2, S1};

    always_comb begin
        res_d      = s_vec;
        all_zero_d = (s_vec == '0);
        all_one_d  = (s_vec == '1);
    end

    // Reset state reports an all-zero result so the flags stay consistent with q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q      <= '0;
            all_zero_q <= 1'b1;
            all_one_q  <= 1'b0;
        end else begin
            res_q      <= res_d;
            all_zero_q <= all_zero_d;
            all_one_q  <= all_one_d;
        end
    end

    assign q        = res_q;
    assign all_zero = all_zero_q;
    assign all_one  = all_one_q;

endmodule

// File: tb/tb_and8_bits_structure.sv
// -----------------------------------------------------------------------------
// tb_and8_bits_structure
//   Directed testbench for and8_bits_structure. Each scenario task drives its
//   own vectors and compares the combinational and registered outputs against
//   hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_and8_bits_structure;

    logic       clk;
    logic       rst_n;
    logic [7:0] a_v;
    logic [7:0] b_v;
    logic       S1, S2, S3, S4, S5, S6, S7, S8;
    logic [7:0] q;
    logic       all_zero;
    logic       all_one;
    logic [7:0] s_obs;

    int checks;
    int failures;

    and8_bits_structure dut (
        .A1(a_v[0]), .B1(b_v[0]),
        .A2(a_v[1]), .B2(b_v[1]),
        .A3(a_v[2]), .B3(b_v[2]),
        .A4(a_v[3]), .B4(b_v[3]),
        .A5(a_v[4]), .B5(b_v[4]),
        .A6(a_v[5]), .B6(b_v[5]),
        .A7(a_v[6]), .B7(b_v[6]),
        .A8(a_v[7]), .B8(b_v[7]),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4),
        .S5(S5), .S6(S6), .S7(S7), .S8(S8),
        .clk(clk),
        .rst_n(rst_n),
        .q(q),
        .all_zero(all_zero),
        .all_one(all_one)
    );

    assign s_obs = {S8, S7, S6, S5, S4, S3, S2, S1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset asserted from time 0 (with a real falling edge); no clock edge seen yet.
    task automatic test_reset();
        a_v = 8'h00;
        b_v = 8'h00;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00) begin
            failures++;
            $display("FAIL reset_q: got %h expected %h", q, 8'h00);
        end
        checks++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_all_zero: got %b expected %b", all_zero, 1'b1);
        end
        checks++;
        if (all_one !== 1'b0) begin
            failures++;
            $display("FAIL reset_all_one: got %b expected %b", all_one, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Table of operand pairs with hand-computed result and flags.
    task automatic test_basic_vectors();
        logic [7:0] ta  [4];
        logic [7:0] tb  [4];
        logic [7:0] ts  [4];
        logic       tz  [4];
        logic       to  [4];
        ta[0] = 8'hFF; tb[0] = 8'h00; ts[0] = 8'h00; tz[0] = 1'b1; to[0] = 1'b0;
        ta[1] = 8'hFF; tb[1] = 8'hA9; ts[1] = 8'hA9; tz[1] = 1'b0; to[1] = 1'b0;
        ta[2] = 8'hFF; tb[2] = 8'hFF; ts[2] = 8'hFF; tz[2] = 1'b0; to[2] = 1'b1;
        ta[3] = 8'h3C; tb[3] = 8'h0F; ts[3] = 8'h0C; tz[3] = 1'b0; to[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_v = ta[i];
            b_v = tb[i];
            #1;
            checks++;
            if (s_obs !== ts[i]) begin
                failures++;
                $display("FAIL basic_s[%0d]: got %h expected %h", i, s_obs, ts[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (q !== ts[i]) begin
                failures++;
                $display("FAIL basic_q[%0d]: got %h expected %h", i, q, ts[i]);
            end
            checks++;
            if (all_zero !== tz[i]) begin
                failures++;
                $display("FAIL basic_all_zero[%0d]: got %b expected %b", i, all_zero, tz[i]);
            end
            checks++;
            if (all_one !== to[i]) begin
                failures++;
                $display("FAIL basic_all_one[%0d]: got %b expected %b", i, all_one, to[i]);
            end
        end
    endtask

    // One-cycle latency: q must still show the previous sample just before the edge.
    task automatic test_latency();
        @(negedge clk);
        a_v = 8'hF0;
        b_v = 8'h3C;
        @(posedge clk);
        #1;
        @(negedge clk);
        a_v = 8'h0F;
        b_v = 8'hFF;
        #1;
        checks++;
        if (q !== 8'h30) begin
            failures++;
            $display("FAIL latency_q_hold: got %h expected %h", q, 8'h30);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q !== 8'h0F) begin
            failures++;
            $display("FAIL latency_q_update: got %h expected %h", q, 8'h0F);
        end
    endtask

    // Reset held low while clocking: S tracks inputs, registers stay at reset values.
    task automatic test_reset_hold();
        @(negedge clk);
        rst_n = 1'b0;
        a_v = 8'hFF;
        b_v = 8'hFF;
        #1;
        checks++;
        if (s_obs !== 8'hFF) begin
            failures++;
            $display("FAIL hold_s: got %h expected %h", s_obs, 8'hFF);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q !== 8'h00) begin
                failures++;
                $display("FAIL hold_q[%0d]: got %h expected %h", c, q, 8'h00);
            end
            checks++;
            if (all_zero !== 1'b1 || all_one !== 1'b0) begin
                failures++;
                $display("FAIL hold_flags[%0d]: got z=%b o=%b expected z=1 o=0", c, all_zero, all_one);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (q !== 8'hFF || all_one !== 1'b1 || all_zero !== 1'b0) begin
            failures++;
            $display("FAIL release_first_edge: got q=%h z=%b o=%b expected q=ff z=0 o=1", q, all_zero, all_one);
        end
    endtask

    // Asynchronous assertion between edges clears q at once.
    task automatic test_async_reset();
        @(negedge clk);
        a_v = 8'hFF;
        b_v = 8'hFF;
        @(posedge clk);
        #2;
        checks++;
        if (q !== 8'hFF) begin
            failures++;
            $display("FAIL async_pre_q: got %h expected %h", q, 8'hFF);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || all_zero !== 1'b1 || all_one !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: got q=%h z=%b o=%b expected q=00 z=1 o=0", q, all_zero, all_one);
        end
        checks++;
        if (s_obs !== 8'hFF) begin
            failures++;
            $display("FAIL async_s_tracks: got %h expected %h", s_obs, 8'hFF);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Walking one on B with A all ones: exactly one S bit set per step.
    task automatic test_walking_one();
        logic [7:0] exp_v;
        for (int k = 0; k < 8; k++) begin
            exp_v = 8'h01 << k;
            @(negedge clk);
            a_v = 8'hFF;
            b_v = exp_v;
            #1;
            checks++;
            if (s_obs !== exp_v) begin
                failures++;
                $display("FAIL walk_s[%0d]: got %h expected %h", k, s_obs, exp_v);
            end
            @(posedge clk);
            #1;
            checks++;
            if (q !== exp_v || all_zero !== 1'b0 || all_one !== 1'b0) begin
                failures++;
                $display("FAIL walk_q[%0d]: got q=%h z=%b o=%b expected q=%h z=0 o=0", k, q, all_zero, all_one, exp_v);
            end
        end
    endtask

    // Complementary patterns AND to zero.
    task automatic test_alternating();
        @(negedge clk);
        a_v = 8'h55;
        b_v = 8'hAA;
        #1;
        checks++;
        if (s_obs !== 8'h00) begin
            failures++;
            $display("FAIL alt_s: got %h expected %h", s_obs, 8'h00);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q !== 8'h00 || all_zero !== 1'b1 || all_one !== 1'b0) begin
            failures++;
            $display("FAIL alt_q: got q=%h z=%b o=%b expected q=00 z=1 o=0", q, all_zero, all_one);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        a_v      = 8'h00;
        b_v      = 8'h00;
        test_reset();
        test_basic_vectors();
        test_latency();
        test_reset_hold();
        test_async_reset();
        test_walking_one();
        test_alternating();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion by 100000");
        $fatal(1);
    end

endmodule
